sysid_boot_checker: RTL and testbench
=====================================

Name: sysid_boot_checker

Overview:
- Avalon-MM master that sequences reads of the system ID slave and checks the values against build-time constants.
- Reads the ID word at address 0, then the timestamp word at address 1, and compares both.
- Reports done, pass and an error code, which gate CPU/peripheral release logic after reset.
- Handles waitrequest stalls with a per-read timeout and bounded retries.

Parameters:
- EXPECTED_ID, 32'd0: required value of the word at address 0.
- EXPECTED_TIMESTAMP, 32'd1489438142: required value of the word at address 1.
- TIMEOUT_CYCLES, 16: stalled cycles allowed per read attempt before it is abandoned; range 2..255.
- MAX_RETRIES, 2: total retries allowed per check run, shared across both reads; range 0..15.
- AUTO_START, 1: when 1, a check run starts automatically on the first cycle after reset deasserts.

Ports:
- clock, in, 1: single clock for all logic.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request to begin a check run.
- avm_address, out, 1: word select; 0 = ID, 1 = timestamp.
- avm_read, out, 1: Avalon read strobe.
- avm_waitrequest, in, 1: slave stall.
- avm_readdata, in, 32: slave data, valid on the cycle avm_read=1 and avm_waitrequest=0 (zero read latency).
- busy, out, 1: a check run is in progress.
- done, out, 1: the last run finished; held until the next start.
- pass, out, 1: the last run matched both words; meaningful only while done=1.
- err_code, out, 2: 0 ok, 1 ID mismatch, 2 timestamp mismatch, 3 timeout.
- id_read, out, 32: last captured ID word.
- ts_read, out, 32: last captured timestamp word.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; timeout and retry counters 0.
  - an auto-start pending flag is set to AUTO_START.
- Reset mid-run: the run is abandoned; avm_read=0 and all outputs are cleared at the reset edge; no partial result is reported.
- States and transitions:
  - IDLE: go to RD_ID if start=1 or the auto-start flag is set; the flag clears on leaving IDLE.
  - RD_ID: avm_read=1, avm_address=0.
    - waitrequest=0: id_read <= readdata; go to RD_TS.
    - waitrequest=1: increment the timeout counter.
  - RD_TS: same handshake with avm_address=1.
    - On accept: ts_read <= readdata; go to CMP.
  - CMP: one cycle, avm_read=0.
    - pass <= (id_read==EXPECTED_ID) && (ts_read==EXPECTED_TIMESTAMP).
    - err_code <= 1 if ID differs (ID has priority), else 2 if timestamp differs, else 0.
    - Go to DONE.
  - RETRY: one cycle, avm_read=0, then return to the read state that timed out.
  - DONE: done=1, busy=0. start=1 clears done, pass and err_code and goes to RD_ID the same edge; id_read and ts_read keep their values until recaptured.
- busy=1 in RD_ID, RD_TS, CMP and RETRY.
- start is ignored while busy=1.
- Timeout rule:
  - The timeout counter clears on entering any read state.
  - If the counter equals TIMEOUT_CYCLES-1 and waitrequest=1 at an edge, the attempt is abandoned.
  - If retries < MAX_RETRIES: retries++, go to RETRY.
  - Otherwise go to DONE with err_code=3 and pass=0.
  - The retry counter clears only on start or auto-start.
- Simultaneous events:
  - If a read is accepted on the same edge the timeout would fire, acceptance wins.
  - avm_read drops in the cycle after acceptance, because the state changes; no double-read of the same address.
- Latency with no stalls: start sampled at edge E; avm_read high after E; ID captured at E+1, timestamp at E+2; CMP after E+2; done, pass and err_code valid after E+3.
- avm_address and avm_read must be registered outputs and held stable while waitrequest=1.

Test Plan:
- AUTO_START=1, slave returns 0 and 1489438142 with no stall → done=1, pass=1, err_code=0 on the fourth cycle after reset deasserts; exactly two read transfers observed.
- start with slave ID returning 32'h1 → done=1, pass=0, err_code=1, id_read=1; a timestamp mismatch injected in the same run still reports 1.
- waitrequest held 5 cycles on the timestamp read with TIMEOUT_CYCLES=16 → address=1 and read held steady for 6 cycles; pass=1, retry count 0.
- waitrequest stuck high with TIMEOUT_CYCLES=4, MAX_RETRIES=2 → three attempts of 4 cycles each separated by 1-cycle gaps; then done=1, err_code=3, pass=0.
- Reset asserted during RD_TS stall → next cycle avm_read=0, busy=0, done=0; with AUTO_START=1 a new run begins at address 0.
- start pulsed while busy, then again in DONE → first pulse ignored; second clears done for one run and repeats the check with identical results.

Source files
------------

// File: rtl/sysid_boot_checker.sv
// ============================================================================
// Module   : sysid_boot_checker
// Brief    : Avalon-MM master that reads the system ID and timestamp words
//            after reset and checks them against build-time constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1489438142,
  parameter int          TIMEOUT_CYCLES     = 16,
  parameter int          MAX_RETRIES        = 2,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_read,
  output logic [31:0] ts_read
);

  localparam logic [7:0] c_tmo_last    = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] c_max_retries = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CMP   = 3'd3,
    S_RETRY = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_auto_pend;
  logic [7:0]  r_tmo_cnt;
  logic [3:0]  r_retries;
  logic        r_avm_address;
  logic        r_avm_read;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [1:0]  r_err_code;
  logic [31:0] r_id_read;
  logic [31:0] r_ts_read;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_auto_pend   <= AUTO_START;
      r_tmo_cnt     <= 8'd0;
      r_retries     <= 4'd0;
      r_avm_address <= 1'b0;
      r_avm_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err_code    <= 2'd0;
      r_id_read     <= 32'd0;
      r_ts_read     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start || (r_state == S_IDLE && r_auto_pend)) begin
            r_auto_pend   <= 1'b0;
            r_state       <= S_RD_ID;
            r_tmo_cnt     <= 8'd0;
            r_retries     <= 4'd0;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_code    <= 2'd0;
          end
        end
        S_RD_ID, S_RD_TS: begin
          // Acceptance is tested first so it wins over a coincident timeout.
          if (!avm_waitrequest) begin
            r_tmo_cnt <= 8'd0;
            if (r_state == S_RD_ID) begin
              r_id_read     <= avm_readdata;
              r_avm_address <= 1'b1;
              r_state       <= S_RD_TS;
            end else begin
              r_ts_read  <= avm_readdata;
              r_avm_read <= 1'b0;
              r_state    <= S_CMP;
            end
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_tmo_cnt  <= 8'd0;
            r_avm_read <= 1'b0;
            if (r_retries < c_max_retries) begin
              r_retries <= r_retries + 4'd1;
              r_state   <= S_RETRY;
            end else begin
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_pass     <= 1'b0;
              r_err_code <= 2'd3;
              r_state    <= S_DONE;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        S_CMP: begin
          r_pass <= (r_id_read == EXPECTED_ID) && (r_ts_read == EXPECTED_TIMESTAMP);
          if (r_id_read != EXPECTED_ID)
            r_err_code <= 2'd1;
          else if (r_ts_read != EXPECTED_TIMESTAMP)
            r_err_code <= 2'd2;
          else
            r_err_code <= 2'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_RETRY: begin
          // The held address remembers which read timed out.
          r_tmo_cnt  <= 8'd0;
          r_avm_read <= 1'b1;
          r_state    <= r_avm_address ? S_RD_TS : S_RD_ID;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign avm_address = r_avm_address;
  assign avm_read    = r_avm_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_code    = r_err_code;
  assign id_read     = r_id_read;
  assign ts_read     = r_ts_read;

endmodule

`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
// ============================================================================
// Module   : tb_sysid_boot_checker
// Brief    : Directed self-checking bench for sysid_boot_checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sysid_boot_checker;

  localparam logic [31:0] c_ts_ok = 32'd1489438142;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        waitreq;
  logic [31:0] id_val;
  logic [31:0] ts_val;
  logic [31:0] rdata;

  logic        d1_addr, d1_read, d1_busy, d1_done, d1_pass;
  logic [1:0]  d1_err;
  logic [31:0] d1_id, d1_ts;
  logic        d2_addr, d2_read, d2_busy, d2_done, d2_pass;
  logic [1:0]  d2_err;
  logic [31:0] d2_id, d2_ts;

  int errors = 0;
  int checks = 0;
  int n_xfer;

  always #5 clk = ~clk;

  // Zero-latency slave: the word is selected by the main DUT's address.
  assign rdata = d1_addr ? ts_val : id_val;

  sysid_boot_checker dut1 (
    .clock(clk), .reset(rst), .start(start),
    .avm_address(d1_addr), .avm_read(d1_read),
    .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .busy(d1_busy), .done(d1_done), .pass(d1_pass), .err_code(d1_err),
    .id_read(d1_id), .ts_read(d1_ts)
  );

  sysid_boot_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(2), .AUTO_START(1'b0)) dut2 (
    .clock(clk), .reset(rst), .start(start),
    .avm_address(d2_addr), .avm_read(d2_read),
    .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .err_code(d2_err),
    .id_read(d2_id), .ts_read(d2_ts)
  );

  always @(posedge clk) begin
    if (rst)
      n_xfer <= 0;
    else if (d1_read && !waitreq)
      n_xfer <= n_xfer + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; waitreq = 1'b0;
    id_val = 32'd0; ts_val = c_ts_ok;
    tick(2);

    // Reset state
    chk("rst_read",  32'(d1_read), 32'd0);
    chk("rst_busy",  32'(d1_busy), 32'd0);
    chk("rst_done",  32'(d1_done), 32'd0);
    chk("rst_pass",  32'(d1_pass), 32'd0);
    chk("rst_err",   32'(d1_err),  32'd0);
    chk("rst_id",    d1_id,        32'd0);

    // Auto-start, no stalls: result on the fourth edge after release
    rst = 1'b0;
    tick();
    chk("auto_rd_id_read", 32'(d1_read), 32'd1);
    chk("auto_rd_id_addr", 32'(d1_addr), 32'd0);
    chk("auto_busy",       32'(d1_busy), 32'd1);
    chk("auto_d2_idle",    32'(d2_busy), 32'd0);
    tick();
    chk("auto_rd_ts_addr", 32'(d1_addr), 32'd1);
    chk("auto_rd_ts_read", 32'(d1_read), 32'd1);
    tick();
    chk("auto_cmp_read",   32'(d1_read), 32'd0);
    chk("auto_cmp_done",   32'(d1_done), 32'd0);
    tick();
    chk("auto_done", 32'(d1_done), 32'd1);
    chk("auto_pass", 32'(d1_pass), 32'd1);
    chk("auto_err",  32'(d1_err),  32'd0);
    chk("auto_busy0", 32'(d1_busy), 32'd0);
    chk("auto_id",   d1_id, 32'd0);
    chk("auto_ts",   d1_ts, c_ts_ok);
    chk("auto_xfers", 32'(n_xfer), 32'd2);

    // ID mismatch with timestamp mismatch too: ID has priority
    id_val = 32'h1; ts_val = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idmm_done_clr", 32'(d1_done), 32'd0);
    chk("idmm_busy",     32'(d1_busy), 32'd1);
    tick(3);
    chk("idmm_done", 32'(d1_done), 32'd1);
    chk("idmm_pass", 32'(d1_pass), 32'd0);
    chk("idmm_err",  32'(d1_err),  32'd1);
    chk("idmm_id",   d1_id, 32'h1);
    chk("idmm_ts",   d1_ts, 32'd5);

    // Timestamp-only mismatch
    id_val = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    chk("tsmm_done", 32'(d1_done), 32'd1);
    chk("tsmm_pass", 32'(d1_pass), 32'd0);
    chk("tsmm_err",  32'(d1_err),  32'd2);

    // 5-cycle stall on the timestamp read, no retry needed
    ts_val = c_ts_ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    waitreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr", 32'(d1_addr), 32'd1);
      chk("stall_read", 32'(d1_read), 32'd1);
      tick();
    end
    chk("stall_addr6", 32'(d1_addr), 32'd1);
    chk("stall_read6", 32'(d1_read), 32'd1);
    waitreq = 1'b0;
    tick();
    chk("stall_rd_drop", 32'(d1_read), 32'd0);
    tick();
    chk("stall_done", 32'(d1_done), 32'd1);
    chk("stall_pass", 32'(d1_pass), 32'd1);
    chk("stall_err",  32'(d1_err),  32'd0);

    // Stuck waitrequest on the TIMEOUT_CYCLES=4 instance
    waitreq = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a < 3; a++) begin
      for (int c = 0; c < 4; c++) begin
        chk("tmo_read_hi", 32'(d2_read), 32'd1);
        chk("tmo_addr",    32'(d2_addr), 32'd0);
        tick();
      end
      chk("tmo_read_lo", 32'(d2_read), 32'd0);
      if (a < 2) begin
        chk("tmo_gap_busy", 32'(d2_busy), 32'd1);
        chk("tmo_gap_done", 32'(d2_done), 32'd0);
        tick();
      end
    end
    chk("tmo_done", 32'(d2_done), 32'd1);
    chk("tmo_err",  32'(d2_err),  32'd3);
    chk("tmo_pass", 32'(d2_pass), 32'd0);
    chk("tmo_busy", 32'(d2_busy), 32'd0);

    // Reset during an RD_TS stall, then auto-start again
    rst = 1'b1; waitreq = 1'b0;
    tick();
    rst = 1'b0;
    tick(2);
    waitreq = 1'b1;
    tick();
    chk("rmid_stall_addr", 32'(d1_addr), 32'd1);
    chk("rmid_stall_read", 32'(d1_read), 32'd1);
    rst = 1'b1;
    tick();
    chk("rmid_read", 32'(d1_read), 32'd0);
    chk("rmid_busy", 32'(d1_busy), 32'd0);
    chk("rmid_done", 32'(d1_done), 32'd0);
    rst = 1'b0; waitreq = 1'b0;
    tick();
    chk("rmid_auto_read", 32'(d1_read), 32'd1);
    chk("rmid_auto_addr", 32'(d1_addr), 32'd0);
    tick(3);
    chk("rmid_done2", 32'(d1_done), 32'd1);
    chk("rmid_pass2", 32'(d1_pass), 32'd1);

    // start while busy is ignored; start in DONE repeats the run
    start = 1'b1;
    tick();
    chk("busy_start_rd", 32'(d1_addr), 32'd0);
    tick();
    start = 1'b0;
    chk("busy_ign_addr", 32'(d1_addr), 32'd1);
    tick(2);
    chk("busy_ign_done", 32'(d1_done), 32'd1);
    chk("busy_ign_pass", 32'(d1_pass), 32'd1);
    chk("busy_ign_xfer", 32'(n_xfer), 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rerun_done_clr", 32'(d1_done), 32'd0);
    tick(3);
    chk("rerun_done", 32'(d1_done), 32'd1);
    chk("rerun_pass", 32'(d1_pass), 32'd1);
    chk("rerun_err",  32'(d1_err),  32'd0);
    chk("rerun_id",   d1_id, 32'd0);
    chk("rerun_ts",   d1_ts, c_ts_ok);
    chk("rerun_xfer", 32'(n_xfer), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
